// File: rtl/bg_sr_scanout.sv
// bg_sr_scanout: background VRAM serial-port scan-out stage.
// Once per line it wins the shared VRAM bus, runs a read transfer cycle that
// loads the VRAM serial register from {ROW,COL}, gives the bus back, and then
// clocks SC once per active pixel while registering SQ onto PIX.
// Optional feature: define BG_SR_FINE_SCROLL_EN to discard FINE leading
// columns with SC pulses before the first visible pixel.
module bg_sr_scanout #(
  parameter int LINE_PIX = 256,
  parameter int RAS_CYC  = 2,
  parameter int SQ_LAT   = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_PIX,
  input  logic        LINE_START,
  input  logic        HBLANK,
  input  logic [7:0]  ROW,
  input  logic [7:0]  COL,
  input  logic [2:0]  FINE,
  output logic        XFER_REQ,
  input  logic        XFER_GNT,
  output logic [15:0] VA,
  output logic        VRAS_N,
  output logic        VOE_N,
  output logic        VWE_N,
  output logic        SC,
  output logic        SE_N,
  input  logic [7:0]  SQ,
  output logic [7:0]  PIX,
  output logic        PIX_VALID,
  output logic        BUSY
);

  localparam int RAS_W  = (RAS_CYC > 1) ? $clog2(RAS_CYC) : 1;
  localparam int WAIT_W = $clog2(SQ_LAT + 2);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RAS,
    REL,
    ARM,
    SHIFT
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [7:0]          row_q;
  logic [7:0]          col_q;
  logic [RAS_W-1:0]    ras_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [8:0]          pix_cnt;
  logic                abort;
  logic                armed;
  logic                ras_last;
  logic                last_pix;
  logic                pix_evt;
  logic                disc_evt;
  logic                disc_done;

  // The transfer cycle never writes the VRAM.
  assign VWE_N = 1'b1;

  assign abort    = LINE_START && (state != IDLE);
  assign armed    = (wait_cnt == '0);
  assign ras_last = (ras_cnt == RAS_W'(RAS_CYC - 1));
  assign last_pix = (pix_cnt == 9'(LINE_PIX - 1));

  // A pixel is taken on an active CE_PIX in SHIFT, or on the first active
  // CE_PIX in ARM once SQ has settled and any discard pulses are done.
  assign pix_evt = CE_PIX && !HBLANK &&
                   ((state == SHIFT) || ((state == ARM) && armed && disc_done));

`ifdef BG_SR_FINE_SCROLL_EN
  logic [2:0] fine_left;

  assign disc_evt  = (state == ARM) && armed && (fine_left != 3'd0);
  assign disc_done = (fine_left == 3'd0);

  // Remaining fine-scroll discard pulses for the current line.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fine_left <= 3'd0;
    end else if (LINE_START) begin
      fine_left <= FINE;
    end else if (disc_evt) begin
      fine_left <= fine_left - 3'd1;
    end
  end
`else
  logic unused_fine;

  assign unused_fine = ^FINE;
  assign disc_evt    = 1'b0;
  assign disc_done   = 1'b1;
`endif

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; a new LINE_START outside IDLE restarts the fetch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (LINE_START) state_nx = REQ;
      REQ:     if (XFER_GNT) state_nx = RAS;
      RAS:     if (ras_last) state_nx = REL;
      REL:     state_nx = ARM;
      ARM:     if (pix_evt) state_nx = SHIFT;
      SHIFT:   state_nx = SHIFT;
      default: state_nx = IDLE;
    endcase
    if (pix_evt && last_pix) begin
      state_nx = IDLE;
    end
    if (abort) begin
      state_nx = REQ;
    end
  end

  // Line parameters, RAS width, SQ settle wait and pixel count.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      row_q    <= 8'd0;
      col_q    <= 8'd0;
      ras_cnt  <= '0;
      wait_cnt <= '0;
      pix_cnt  <= 9'd0;
    end else begin
      if (LINE_START) begin
        row_q <= ROW;
        col_q <= COL;
      end

      if ((state == RAS) && (state_nx == RAS)) begin
        ras_cnt <= ras_cnt + RAS_W'(1);
      end else begin
        ras_cnt <= '0;
      end

      if ((state != ARM) && (state_nx == ARM)) begin
        wait_cnt <= WAIT_W'(SQ_LAT);
      end else if (disc_evt) begin
        wait_cnt <= WAIT_W'(SQ_LAT + 1);
      end else if ((state == ARM) && !armed) begin
        wait_cnt <= wait_cnt - WAIT_W'(1);
      end

      if (LINE_START) begin
        pix_cnt <= 9'd0;
      end else if (pix_evt) begin
        pix_cnt <= pix_cnt + 9'd1;
      end
    end
  end

  // Bus and status outputs are registered from the next state so they are glitch-free.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      XFER_REQ <= 1'b0;
      VA       <= 16'd0;
      VRAS_N   <= 1'b1;
      VOE_N    <= 1'b1;
      SE_N     <= 1'b1;
      BUSY     <= 1'b0;
    end else begin
      XFER_REQ <= (state_nx == REQ) || (state_nx == RAS);
      VA       <= (state_nx == RAS) ? {row_q, col_q} : 16'd0;
      VRAS_N   <= (state_nx != RAS);
      VOE_N    <= (state_nx != RAS);
      SE_N     <= (state_nx != SHIFT);
      BUSY     <= (state_nx != IDLE);
    end
  end

  // Pixel capture and one-CLK SC pulses; an abort suppresses SC but keeps a coincident pixel.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      SC        <= 1'b0;
      PIX       <= 8'd0;
      PIX_VALID <= 1'b0;
    end else begin
      SC <= (pix_evt || disc_evt) && !abort;
      if (pix_evt) begin
        PIX       <= SQ;
        PIX_VALID <= 1'b1;
      end else if (abort || CE_PIX) begin
        PIX_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bg_sr_scanout.sv
// tb_bg_sr_scanout: directed bench for bg_sr_scanout with a small VRAM
// serial-port model (column n holds value n).
`timescale 1ns/1ps
module tb_bg_sr_scanout;

  localparam int LINE_PIX = 256;
  localparam int RAS_CYC  = 2;
  localparam int SQ_LAT   = 2;
`ifdef BG_SR_FINE_SCROLL_EN
  localparam int FINE_EXP = 3;
`else
  localparam int FINE_EXP = 0;
`endif

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        CE_PIX = 1'b0;
  logic        LINE_START = 1'b0;
  logic        HBLANK = 1'b0;
  logic [7:0]  ROW = 8'd0;
  logic [7:0]  COL = 8'd0;
  logic [2:0]  FINE = 3'd0;
  logic        XFER_REQ;
  logic        XFER_GNT = 1'b0;
  logic [15:0] VA;
  logic        VRAS_N;
  logic        VOE_N;
  logic        VWE_N;
  logic        SC;
  logic        SE_N;
  logic [7:0]  SQ = 8'hEE;
  logic [7:0]  PIX;
  logic        PIX_VALID;
  logic        BUSY;

  int checks = 0;
  int failures = 0;

  int         sc_count = 0;
  int         sc_wide = 0;
  int         sq_timer = 0;
  logic       sc_prev = 1'b0;
  logic       ras_prev = 1'b1;
  logic [7:0] ptr = 8'd0;

  bg_sr_scanout #(
    .LINE_PIX(LINE_PIX),
    .RAS_CYC (RAS_CYC),
    .SQ_LAT  (SQ_LAT)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .CE_PIX    (CE_PIX),
    .LINE_START(LINE_START),
    .HBLANK    (HBLANK),
    .ROW       (ROW),
    .COL       (COL),
    .FINE      (FINE),
    .XFER_REQ  (XFER_REQ),
    .XFER_GNT  (XFER_GNT),
    .VA        (VA),
    .VRAS_N    (VRAS_N),
    .VOE_N     (VOE_N),
    .VWE_N     (VWE_N),
    .SC        (SC),
    .SE_N      (SE_N),
    .SQ        (SQ),
    .PIX       (PIX),
    .PIX_VALID (PIX_VALID),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  // VRAM serial port: transfer loads the column pointer, each SC falling edge
  // advances it, and SQ shows the new column SQ_LAT CLK later.
  always @(negedge CLK) begin
    if (sq_timer > 0) begin
      sq_timer = sq_timer - 1;
      if (sq_timer == 0) SQ = ptr;
    end
    if (ras_prev && !VRAS_N && !VOE_N) begin
      ptr = VA[7:0];
      sq_timer = SQ_LAT;
    end
    if (sc_prev && !SC) begin
      ptr = ptr + 8'd1;
      sq_timer = SQ_LAT;
    end
    if (SC) sc_count = sc_count + 1;
    if (SC && sc_prev) sc_wide = sc_wide + 1;
    sc_prev = SC;
    ras_prev = VRAS_N;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] row, input logic [7:0] col, input logic [2:0] fine);
    @(negedge CLK);
    ROW = row;
    COL = col;
    FINE = fine;
    LINE_START = 1'b1;
    @(negedge CLK);
    LINE_START = 1'b0;
  endtask

  task automatic grantBus();
    int n;
    n = 0;
    while (XFER_REQ !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("gnt_req_seen", XFER_REQ, 1);
    XFER_GNT = 1'b1;
    @(negedge CLK);
    XFER_GNT = 1'b0;
  endtask

  task automatic pixelTick(input logic hb, output logic [7:0] p, output logic v);
    @(negedge CLK);
    CE_PIX = 1'b1;
    HBLANK = hb;
    @(negedge CLK);
    CE_PIX = 1'b0;
    HBLANK = 1'b0;
    p = PIX;
    v = PIX_VALID;
    repeat (3) @(negedge CLK);
  endtask

  initial begin
    logic [7:0] p;
    logic       v;
    int         base;
    logic [7:0] wrap_exp [4];

    wrap_exp[0] = 8'hFE;
    wrap_exp[1] = 8'hFF;
    wrap_exp[2] = 8'h00;
    wrap_exp[3] = 8'h01;

    repeat (2) @(negedge CLK);
    checkOutput("rst_xfer_req", XFER_REQ, 0);
    checkOutput("rst_va", VA, 0);
    checkOutput("rst_vras_n", VRAS_N, 1);
    checkOutput("rst_voe_n", VOE_N, 1);
    checkOutput("rst_vwe_n", VWE_N, 1);
    checkOutput("rst_sc", SC, 0);
    checkOutput("rst_se_n", SE_N, 1);
    checkOutput("rst_pix", PIX, 0);
    checkOutput("rst_pix_valid", PIX_VALID, 0);
    checkOutput("rst_busy", BUSY, 0);
    RST_N = 1'b1;
    @(negedge CLK);

    // Transfer cycle with a late grant that drops during RAS.
    applyStimulus(8'h12, 8'h34, 3'd0);
    checkOutput("req_asserted", XFER_REQ, 1);
    checkOutput("req_busy", BUSY, 1);
    repeat (3) @(negedge CLK);
    checkOutput("req_held", XFER_REQ, 1);
    checkOutput("req_no_ras", VRAS_N, 1);
    XFER_GNT = 1'b1;
    @(negedge CLK);
    XFER_GNT = 1'b0;
    checkOutput("ras1_va", VA, 16'h1234);
    checkOutput("ras1_vras_n", VRAS_N, 0);
    checkOutput("ras1_voe_n", VOE_N, 0);
    checkOutput("ras1_vwe_n", VWE_N, 1);
    checkOutput("ras1_xfer_req", XFER_REQ, 1);
    @(negedge CLK);
    checkOutput("ras2_va", VA, 16'h1234);
    checkOutput("ras2_vras_n", VRAS_N, 0);
    checkOutput("ras2_voe_n", VOE_N, 0);
    @(negedge CLK);
    checkOutput("rel_vras_n", VRAS_N, 1);
    checkOutput("rel_voe_n", VOE_N, 1);
    checkOutput("rel_xfer_req", XFER_REQ, 0);
    checkOutput("rel_va", VA, 0);
    repeat (25) @(negedge CLK);
    pixelTick(1'b0, p, v);
    checkOutput("a_pix0", {v, p}, {1'b1, 8'h34});
    checkOutput("a_se_n", SE_N, 0);
    pixelTick(1'b0, p, v);
    checkOutput("a_pix1", {v, p}, {1'b1, 8'h35});

    // Full line from column 0.
    applyStimulus(8'h00, 8'h00, 3'd0);
    grantBus();
    repeat (25) @(negedge CLK);
    base = sc_count;
    for (int i = 0; i < LINE_PIX; i++) begin
      pixelTick(1'b0, p, v);
      checkOutput("line_pix", {v, p}, {1'b1, 8'(i)});
    end
    checkOutput("line_sc_count", sc_count - base, LINE_PIX);
    checkOutput("line_busy_end", BUSY, 0);
    checkOutput("line_se_n_end", SE_N, 1);
    pixelTick(1'b0, p, v);
    checkOutput("eol_valid_clear", v, 0);
    checkOutput("eol_no_sc", sc_count - base, LINE_PIX);

    // Column wrap inside the VRAM.
    applyStimulus(8'h00, 8'hFE, 3'd0);
    grantBus();
    repeat (25) @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      pixelTick(1'b0, p, v);
      checkOutput("wrap_pix", {v, p}, {1'b1, wrap_exp[i]});
    end

    // HBLANK mid-line: no SC, no valid pixels, then resume at column 0x02.
    base = sc_count;
    for (int i = 0; i < 10; i++) begin
      pixelTick(1'b1, p, v);
      checkOutput("hblank_valid", v, 0);
    end
    checkOutput("hblank_no_sc", sc_count - base, 0);
    pixelTick(1'b0, p, v);
    checkOutput("hblank_resume0", {v, p}, {1'b1, 8'h02});
    pixelTick(1'b0, p, v);
    checkOutput("hblank_resume1", {v, p}, {1'b1, 8'h03});

    // Abort during RAS, then abort at pixel 100.
    applyStimulus(8'h55, 8'h10, 3'd0);
    XFER_GNT = 1'b1;
    @(negedge CLK);
    XFER_GNT = 1'b0;
    checkOutput("ab_ras_vras_n", VRAS_N, 0);
    checkOutput("ab_ras_va", VA, 16'h5510);
    ROW = 8'h66;
    COL = 8'h00;
    LINE_START = 1'b1;
    @(negedge CLK);
    LINE_START = 1'b0;
    checkOutput("ab_vras_rise", VRAS_N, 1);
    checkOutput("ab_back_to_req", XFER_REQ, 1);
    checkOutput("ab_va_clear", VA, 0);
    XFER_GNT = 1'b1;
    @(negedge CLK);
    XFER_GNT = 1'b0;
    checkOutput("ab_new_row_va", VA, 16'h6600);
    repeat (25) @(negedge CLK);
    for (int i = 0; i < 100; i++) begin
      pixelTick(1'b0, p, v);
      checkOutput("ab_line_pix", {v, p}, {1'b1, 8'(i)});
    end
    base = sc_count;
    applyStimulus(8'h77, 8'h20, 3'd0);
    checkOutput("ab2_valid_clear", PIX_VALID, 0);
    checkOutput("ab2_sc_low", SC, 0);
    checkOutput("ab2_req", XFER_REQ, 1);
    for (int i = 0; i < 3; i++) begin
      pixelTick(1'b0, p, v);
    end
    checkOutput("ab2_no_sc", sc_count - base, 0);
    XFER_GNT = 1'b1;
    @(negedge CLK);
    XFER_GNT = 1'b0;
    checkOutput("ab2_va", VA, 16'h7720);
    repeat (25) @(negedge CLK);
    pixelTick(1'b0, p, v);
    checkOutput("ab2_first_pix", {v, p}, {1'b1, 8'h20});

    // Fine scroll: FINE leading columns are discarded only with the option.
    applyStimulus(8'h00, 8'h00, 3'd3);
    grantBus();
    base = sc_count;
    repeat (25) @(negedge CLK);
    checkOutput("fine_disc_sc", sc_count - base, FINE_EXP);
    pixelTick(1'b0, p, v);
    checkOutput("fine_first_pix", {v, p}, {1'b1, 8'(FINE_EXP)});

    // Asynchronous reset in the middle of RAS.
    applyStimulus(8'h9A, 8'hBC, 3'd0);
    XFER_GNT = 1'b1;
    @(negedge CLK);
    XFER_GNT = 1'b0;
    checkOutput("mrst_ras_low", VRAS_N, 0);
    #2;
    RST_N = 1'b0;
    #1;
    checkOutput("mrst_vras_n", VRAS_N, 1);
    checkOutput("mrst_busy", BUSY, 0);
    checkOutput("mrst_xfer_req", XFER_REQ, 0);
    checkOutput("mrst_va", VA, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    checkOutput("mrst_idle", BUSY, 0);
    checkOutput("mrst_sc", SC, 0);

    checkOutput("sc_one_clk_wide", sc_wide, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
